// File: rtl/axis_adder.sv
// AXI-Stream element-wise adder tile: buffers operand packet A, then B, then streams A[k]+B[k].
// Define ADDER_SATURATE_EN for an unsigned saturating add; the default build wraps mod 2^TDATAW.
module axis_adder #(
  parameter int unsigned TDATAW    = 32,
  parameter int unsigned TDESTW    = 4,
  parameter int unsigned TIDW      = 2,
  parameter int unsigned MAX_FLITS = 8,
  parameter int unsigned DEST_ID   = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TDESTW-1:0] AXIS_M_TDEST
);

  localparam int unsigned CNTW = $clog2(MAX_FLITS + 1);
  localparam int unsigned IDXW = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
  localparam logic [CNTW-1:0]   MaxCnt  = CNTW'(MAX_FLITS);
  localparam logic [TDESTW-1:0] DestVal = TDESTW'(DEST_ID);

  typedef enum logic [1:0] {RECV_A, RECV_B, SEND} state_e;

  state_e            state_q;
  logic [CNTW-1:0]   cntA_q, cntB_q, lenA_q, lenB_q, k_q;
  logic              sReady_q, mValid_q, mLast_q;
  logic [TDATAW-1:0] mData_q;
  logic [TDESTW-1:0] mDest_q;
  logic [TDATAW-1:0] bufA_q [MAX_FLITS];
  logic [TDATAW-1:0] bufB_q [MAX_FLITS];

  logic              sAccept, wrA, wrB;
  logic [CNTW-1:0]   kNext;
  logic [TDATAW-1:0] bNext, firstB, firstSum_d, nextSum_d;
  logic              unusedInputs;

  assign unusedInputs = ^{AXIS_S_TDEST, TIDW[1:0]};

  function automatic logic [TDATAW-1:0] addOp(input logic [TDATAW-1:0] a,
                                              input logic [TDATAW-1:0] b);
    logic [TDATAW:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef ADDER_SATURATE_EN
    return s[TDATAW] ? '1 : s[TDATAW-1:0];
`else
    return s[TDATAW-1:0];
`endif
  endfunction

  assign sAccept = AXIS_S_TVALID && sReady_q;
  assign wrA     = (state_q == RECV_A) && sAccept && (cntA_q < MaxCnt);
  assign wrB     = (state_q == RECV_B) && sAccept && (cntB_q < MaxCnt);
  assign kNext   = k_q + 1'b1;

  // A single-flit B packet is still in flight when the first sum is formed, so forward it.
  always_comb begin
    bNext = '0;
    if (kNext < lenB_q) bNext = bufB_q[kNext[IDXW-1:0]];
    firstB     = (cntB_q == '0) ? AXIS_S_TDATA : bufB_q[0];
    firstSum_d = addOp(bufA_q[0], firstB);
    nextSum_d  = addOp(bufA_q[kNext[IDXW-1:0]], bNext);
  end

  always_ff @(posedge CLK) begin
    if (wrA) bufA_q[cntA_q[IDXW-1:0]] <= AXIS_S_TDATA;
    if (wrB) bufB_q[cntB_q[IDXW-1:0]] <= AXIS_S_TDATA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= RECV_A;
      cntA_q   <= '0;
      cntB_q   <= '0;
      lenA_q   <= '0;
      lenB_q   <= '0;
      k_q      <= '0;
      sReady_q <= 1'b0;
      mValid_q <= 1'b0;
      mData_q  <= '0;
      mLast_q  <= 1'b0;
      mDest_q  <= '0;
    end else begin
      case (state_q)
        RECV_A: begin
          sReady_q <= 1'b1;
          if (sAccept) begin
            if (cntA_q < MaxCnt) cntA_q <= cntA_q + 1'b1;
            if (AXIS_S_TLAST) begin
              lenA_q  <= (cntA_q < MaxCnt) ? cntA_q + 1'b1 : MaxCnt;
              state_q <= RECV_B;
            end
          end
        end
        RECV_B: begin
          if (sAccept) begin
            if (cntB_q < MaxCnt) cntB_q <= cntB_q + 1'b1;
            if (AXIS_S_TLAST) begin
              lenB_q   <= (cntB_q < MaxCnt) ? cntB_q + 1'b1 : MaxCnt;
              sReady_q <= 1'b0;
              k_q      <= '0;
              mValid_q <= 1'b1;
              mData_q  <= firstSum_d;
              mLast_q  <= (lenA_q == 1);
              mDest_q  <= DestVal;
              state_q  <= SEND;
            end
          end
        end
        SEND: begin
          if (mValid_q && AXIS_M_TREADY) begin
            if (mLast_q) begin
              mValid_q <= 1'b0;
              mLast_q  <= 1'b0;
              sReady_q <= 1'b1;
              cntA_q   <= '0;
              cntB_q   <= '0;
              state_q  <= RECV_A;
            end else begin
              k_q     <= kNext;
              mData_q <= nextSum_d;
              mLast_q <= (kNext == lenA_q - 1'b1);
            end
          end
        end
        default: state_q <= RECV_A;
      endcase
    end
  end

  assign AXIS_S_TREADY = sReady_q;
  assign AXIS_M_TVALID = mValid_q;
  assign AXIS_M_TDATA  = mData_q;
  assign AXIS_M_TLAST  = mLast_q;
  assign AXIS_M_TDEST  = mDest_q;

endmodule

// File: tb/tb_axis_adder.sv
// Directed bench for axis_adder: reset, basic sum, backpressure, overflow, length mismatch,
// mid-packet reset and back-to-back packet pairs.
module tb_axis_adder;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        AXIS_S_TVALID, AXIS_S_TREADY, AXIS_S_TLAST;
  logic [31:0] AXIS_S_TDATA;
  logic [3:0]  AXIS_S_TDEST;
  logic        AXIS_M_TVALID, AXIS_M_TREADY, AXIS_M_TLAST;
  logic [31:0] AXIS_M_TDATA;
  logic [3:0]  AXIS_M_TDEST;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  axis_adder dut (
    .CLK(CLK), .RST_N(RST_N),
    .AXIS_S_TVALID(AXIS_S_TVALID), .AXIS_S_TREADY(AXIS_S_TREADY),
    .AXIS_S_TDATA(AXIS_S_TDATA), .AXIS_S_TLAST(AXIS_S_TLAST), .AXIS_S_TDEST(AXIS_S_TDEST),
    .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(AXIS_M_TREADY),
    .AXIS_M_TDATA(AXIS_M_TDATA), .AXIS_M_TLAST(AXIS_M_TLAST), .AXIS_M_TDEST(AXIS_M_TDEST)
  );

  function automatic void model(input logic [31:0] a[$], input logic [31:0] b[$],
                                output logic [31:0] r[$]);
    int la, lb;
    logic [32:0] s;
    r  = {};
    la = (a.size() > 8) ? 8 : a.size();
    lb = (b.size() > 8) ? 8 : b.size();
    for (int k = 0; k < la; k++) begin
      s = {1'b0, a[k]} + ((k < lb) ? {1'b0, b[k]} : 33'd0);
`ifdef ADDER_SATURATE_EN
      r.push_back(s[32] ? 32'hFFFF_FFFF : s[31:0]);
`else
      r.push_back(s[31:0]);
`endif
    end
  endfunction

  task automatic sendPkt(input logic [31:0] d[$], output bit ok);
    int waited;
    ok = 1'b1;
    foreach (d[i]) begin
      AXIS_S_TVALID = 1'b1;
      AXIS_S_TDATA  = d[i];
      AXIS_S_TLAST  = (i == d.size() - 1);
      AXIS_S_TDEST  = 4'hA;
      waited = 0;
      while (ok) begin
        @(negedge CLK);
        if (AXIS_S_TREADY === 1'b1) break;
        waited++;
        if (waited > 50) ok = 1'b0;
      end
      if (!ok) break;
      @(posedge CLK); #1;
    end
    AXIS_S_TVALID = 1'b0;
    AXIS_S_TLAST  = 1'b0;
  endtask

  task automatic collect(input bit toggle, output logic [31:0] dq[$], output logic lq[$],
                         output logic [3:0] tq[$], output int stallViol, output int sRdyViol,
                         output bit timedOut);
    logic [31:0] pd;
    logic        pl;
    bit          pStall, done;
    dq = {}; lq = {}; tq = {};
    stallViol = 0; sRdyViol = 0; pStall = 1'b0; done = 1'b0; pd = '0; pl = 1'b0;
    AXIS_M_TREADY = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      if (AXIS_M_TVALID === 1'b1 && AXIS_S_TREADY !== 1'b0) sRdyViol++;
      if (pStall && (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== pd || AXIS_M_TLAST !== pl))
        stallViol++;
      pStall = (AXIS_M_TVALID === 1'b1) && (AXIS_M_TREADY === 1'b0);
      pd = AXIS_M_TDATA;
      pl = AXIS_M_TLAST;
      if (AXIS_M_TVALID === 1'b1 && AXIS_M_TREADY === 1'b1) begin
        dq.push_back(AXIS_M_TDATA);
        lq.push_back(AXIS_M_TLAST);
        tq.push_back(AXIS_M_TDEST);
        if (AXIS_M_TLAST === 1'b1) done = 1'b1;
      end
      @(posedge CLK); #1;
      if (toggle) AXIS_M_TREADY = ~AXIS_M_TREADY;
    end
    AXIS_M_TREADY = 1'b1;
    timedOut = !done;
  endtask

  task automatic runPair(input logic [31:0] a[$], input logic [31:0] b[$], input bit toggle,
                         output bit ok, output logic lat, output logic [31:0] dq[$],
                         output logic lq[$], output logic [3:0] tq[$], output int stallViol,
                         output int sRdyViol);
    bit okA, okB, to;
    sendPkt(a, okA);
    sendPkt(b, okB);
    lat = AXIS_M_TVALID;
    collect(toggle, dq, lq, tq, stallViol, sRdyViol, to);
    ok = okA && okB && !to;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; AXIS_S_TVALID = 1'b0; AXIS_S_TLAST = 1'b0; AXIS_S_TDATA = '0;
    AXIS_S_TDEST = '0; AXIS_M_TREADY = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({AXIS_S_TREADY, AXIS_M_TVALID, AXIS_M_TLAST} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {AXIS_S_TREADY, AXIS_M_TVALID, AXIS_M_TLAST});
    end
    checks++;
    if ({AXIS_M_TDATA, AXIS_M_TDEST} !== 36'd0) begin
      errors++; $display("FAIL reset_data: got %h/%h expected 0/0", AXIS_M_TDATA, AXIS_M_TDEST);
    end
    RST_N = 1'b1;
    #1;
    checks++;
    if (AXIS_S_TREADY !== 1'b0) begin
      errors++; $display("FAIL reset_release_early: got %b expected 0", AXIS_S_TREADY);
    end
    @(posedge CLK); #1;
    checks++;
    if ({AXIS_S_TREADY, AXIS_M_TVALID} !== 2'b10) begin
      errors++; $display("FAIL reset_release_edge: got %b expected 10", {AXIS_S_TREADY, AXIS_M_TVALID});
    end
  endtask

  task automatic test_basic(input bit toggle);
    logic [31:0] dq[$], exp[$];
    logic lq[$], lat;
    logic [3:0] tq[$];
    int sv, rv;
    bit ok;
    exp = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55};
    runPair('{32'd1, 32'd2, 32'd3, 32'd4, 32'd5}, '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50},
            toggle, ok, lat, dq, lq, tq, sv, rv);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: got timeout expected completion (toggle=%0d)", toggle); end
    checks++;
    if (lat !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b expected 1", lat); end
    checks++;
    if (dq.size() != 5) begin errors++; $display("FAIL basic_count: got %0d expected 5", dq.size()); end
    for (int i = 0; i < dq.size() && i < 5; i++) begin
      checks++;
      if (dq[i] !== exp[i]) begin errors++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, dq[i], exp[i]); end
      checks++;
      if ({lq[i], tq[i]} !== {(i == 4), 4'd3}) begin
        errors++; $display("FAIL basic_last_dest[%0d]: got %b/%0d expected %b/3", i, lq[i], tq[i], (i == 4));
      end
    end
    checks++;
    if (sv != 0) begin errors++; $display("FAIL stall_hold: got %0d violations expected 0", sv); end
    checks++;
    if (rv != 0) begin errors++; $display("FAIL sready_in_send: got %0d violations expected 0", rv); end
    checks++;
    if ({AXIS_M_TVALID, AXIS_S_TREADY} !== 2'b01) begin
      errors++; $display("FAIL basic_return: got %b expected 01", {AXIS_M_TVALID, AXIS_S_TREADY});
    end
  endtask

  task automatic test_overflow();
    logic [31:0] dq[$], expV;
    logic lq[$], lat;
    logic [3:0] tq[$];
    int sv, rv;
    bit ok;
`ifdef ADDER_SATURATE_EN
    expV = 32'hFFFF_FFFF;
`else
    expV = 32'h1;
`endif
    runPair('{32'hFFFF_FFFF}, '{32'h2}, 1'b0, ok, lat, dq, lq, tq, sv, rv);
    checks++;
    if (!ok || dq.size() != 1) begin
      errors++; $display("FAIL overflow_count: got %0d flits ok=%0d expected 1", dq.size(), ok);
    end else begin
      checks++;
      if ({dq[0], lq[0]} !== {expV, 1'b1}) begin
        errors++; $display("FAIL overflow_data: got %h last %b expected %h last 1", dq[0], lq[0], expV);
      end
    end
  endtask

  task automatic test_length_mismatch();
    logic [31:0] dq[$], exp[$], a[$], b[$];
    logic lq[$], lat;
    logic [3:0] tq[$];
    int sv, rv;
    bit ok;
    runPair('{32'd7, 32'd8, 32'd9}, '{32'd1}, 1'b0, ok, lat, dq, lq, tq, sv, rv);
    exp = '{32'd8, 32'd8, 32'd9};
    checks++;
    if (!ok || dq.size() != 3) begin errors++; $display("FAIL len_longA_count: got %0d expected 3", dq.size()); end
    for (int i = 0; i < dq.size() && i < 3; i++) begin
      checks++;
      if ({dq[i], lq[i]} !== {exp[i], (i == 2)}) begin
        errors++; $display("FAIL len_longA[%0d]: got %0d/%b expected %0d/%b", i, dq[i], lq[i], exp[i], (i == 2));
      end
    end
    runPair('{32'd7}, '{32'd1, 32'd2, 32'd3}, 1'b0, ok, lat, dq, lq, tq, sv, rv);
    checks++;
    if (!ok || dq.size() != 1) begin
      errors++; $display("FAIL len_longB_count: got %0d expected 1", dq.size());
    end else begin
      checks++;
      if ({dq[0], lq[0]} !== {32'd8, 1'b1}) begin
        errors++; $display("FAIL len_longB: got %0d/%b expected 8/1", dq[0], lq[0]);
      end
    end
    a = {}; b = {};
    for (int i = 0; i < 10; i++) a.push_back(32'(i + 1));
    for (int i = 0; i < 9; i++) b.push_back(32'(100 + i));
    model(a, b, exp);
    runPair(a, b, 1'b0, ok, lat, dq, lq, tq, sv, rv);
    checks++;
    if (!ok || dq.size() != 8) begin errors++; $display("FAIL len_sat_count: got %0d expected 8", dq.size()); end
    for (int i = 0; i < dq.size() && i < 8; i++) begin
      checks++;
      if ({dq[i], lq[i]} !== {exp[i], (i == 7)}) begin
        errors++; $display("FAIL len_sat[%0d]: got %0d/%b expected %0d/%b", i, dq[i], lq[i], exp[i], (i == 7));
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] dq[$];
    logic lq[$], lat;
    logic [3:0] tq[$];
    int sv, rv;
    bit ok;
    AXIS_S_TVALID = 1'b1; AXIS_S_TDATA = 32'd40; AXIS_S_TLAST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    AXIS_S_TVALID = 1'b0;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({AXIS_S_TREADY, AXIS_M_TVALID} !== 2'b00) begin
      errors++; $display("FAIL midreset_async: got %b expected 00", {AXIS_S_TREADY, AXIS_M_TVALID});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    runPair('{32'd2}, '{32'd3}, 1'b0, ok, lat, dq, lq, tq, sv, rv);
    checks++;
    if (!ok || dq.size() != 1 || dq[0] !== 32'd5 || lq[0] !== 1'b1) begin
      errors++; $display("FAIL midreset_pkt: got %0d flits first %0d expected 1 flit 5", dq.size(), (dq.size() > 0) ? dq[0] : 32'd0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dq[$], exp[$], a[$], b[$];
    logic lq[$], lat;
    logic [3:0] tq[$];
    int sv, rv, la, lb;
    bit ok;
    for (int p = 0; p < 5; p++) begin
      a = {}; b = {};
      la = $urandom_range(1, 8);
      lb = $urandom_range(1, 8);
      for (int i = 0; i < la; i++) a.push_back($urandom);
      for (int i = 0; i < lb; i++) b.push_back($urandom);
      model(a, b, exp);
      runPair(a, b, p[0], ok, lat, dq, lq, tq, sv, rv);
      checks++;
      if (!ok || dq.size() != exp.size()) begin
        errors++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", p, dq.size(), exp.size());
      end
      for (int i = 0; i < dq.size() && i < exp.size(); i++) begin
        checks++;
        if ({dq[i], lq[i], tq[i]} !== {exp[i], (i == exp.size() - 1), 4'd3}) begin
          errors++; $display("FAIL b2b_flit[%0d][%0d]: got %h/%b/%0d expected %h/%b/3", p, i, dq[i], lq[i], tq[i], exp[i], (i == exp.size() - 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_overflow();
    test_length_mismatch();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
